dac_update_scheduler: RTL and testbench
=======================================

// Module: dac_update_scheduler
// PURPOSE
//  Shares one I2C DAC write controller between NUM_CH sequencer voice channels.
//  - Latches per-channel 12-bit update requests and coalesces them: the newest value wins.
//  - Picks a pending channel round-robin and builds the 32-bit frame {ADDR+W, CMD, MSB, LSB}.
//  - Runs the controller's GO/END handshake.
//  - Retries transfers that were NACKed or timed out, and reports completion and errors.
// PARAMETERS
//  NUM_CH          4      number of requesting channels (1..4, one-hot DAC address nibble)
//  SLAVE_ADDR      7'h0C  7-bit DAC I2C address; frame byte 3 = {SLAVE_ADDR,1'b0}
//  CMD_NIB         4'h3   command nibble (write-and-update); frame byte 2 = {CMD_NIB, 4'b1<<ch}
//  MAX_RETRY       2      extra attempts after a failed transfer (0 = no retry)
//  GAP_CYCLES      4      idle cycles with GO low between transfers (>=1)
//  TIMEOUT_CYCLES  63     maximum cycles in XFER before the transfer counts as failed
// PORTS
//  CLOCK     in   1          system clock; the I2C controller runs on the same clock
//  RESET     in   1          synchronous, active-high reset
//  REQ       in   NUM_CH     per-channel update strobe, sampled every CLOCK edge
//  REQ_DATA  in   12*NUM_CH  channel ch value in bits [12*ch+11:12*ch]
//  ERR_CLR   in   1          clears ERR_STICKY
//  I2C_DATA  out  32         frame to the controller; stable while GO=1
//  GO        out  1          transfer enable; the controller counter runs only while GO=1
//  END       in   1          controller done flag; low while the counter is 0, high after stop
//  ACK       in   1          controller NACK indicator; 1 = any ACK slot sampled high
//  PENDING   out  NUM_CH     pending-update bit per channel
//  BUSY      out  1          1 in any state other than IDLE
//  DONE      out  1          1-cycle pulse when a frame is acknowledged
//  DONE_CH   out  2          channel of the last DONE pulse
//  ERR_STICKY out 1          set when a channel exhausts its retries
//  ERR_CH    out  2          channel of the most recent exhausted failure
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, round-robin pointer=0, shadow values=0, retry count=0.
//   - GO drops on the edge where RESET is sampled, including mid-transfer.
//   - Any in-flight frame is abandoned; nothing is pulsed.
//  Request capture (every edge, in every state):
//   - REQ[ch]=1 -> shadow[ch]<=REQ_DATA slice and PENDING[ch]<=1.
//   - A REQ on the same edge as the channel's completion clear wins: PENDING stays 1 with the new value.
//  Frame: {SLAVE_ADDR,1'b0, CMD_NIB, 4'b1<<ch, shadow[ch][11:4], shadow[ch][3:0],4'b0}.
//   - The frame is latched into I2C_DATA on leaving IDLE.
//   - Later REQs to the same channel only update the shadow; the next transfer carries them.
//  Arbitration: round-robin; first pending channel at or after the pointer, wrapping NUM_CH-1 -> 0.
//   - On success or exhausted failure, the pointer becomes ch+1 mod NUM_CH.
//  State machine:
//   IDLE  : GO=0.
//           - Any PENDING -> select channel, latch frame, clear retry count -> ARM.
//   ARM   : GO=0; wait for END==0, which shows the controller counter has been re-armed.
//           - On END==0 -> XFER; GO=1 from the next edge; clear timeout counter.
//   XFER  : GO=1; count cycles.
//           - END==1 -> CHECK.
//           - Count reaches TIMEOUT_CYCLES -> CHECK with fail flag set.
//   CHECK : GO<=0; sample ACK.
//           - Success (ACK==0 and no timeout): clear PENDING[ch] unless REQ[ch] on this edge; DONE=1; DONE_CH=ch.
//           - Failure with retries < MAX_RETRY: retries+1; PENDING kept; same frame is reused.
//           - Failure with retries exhausted: ERR_STICKY<=1; ERR_CH<=ch; clear PENDING[ch] (same REQ rule as success).
//           - All outcomes -> GAP.
//   GAP   : GO=0 for GAP_CYCLES cycles.
//           - Retry pending -> ARM with the same frame.
//           - Otherwise -> IDLE.
//  Latency: REQ sampled at edge t with the block in IDLE and END low.
//   - PENDING=1 after edge t; IDLE->ARM at t+1; GO=1 after edge t+2.
//   - A nominal transfer holds GO high about 42 cycles.
//  ERR_CLR on the same edge as a new error: set wins.
//  Channel counts and DONE_CH/ERR_CH are zero-extended to 2 bits.
// TESTING
//  1) Single update: REQ[0] at t with 12'hABC; controller model ACKs.
//     -> GO high from t+2; I2C_DATA=32'h1831ABC0; one DONE pulse with DONE_CH=0; PENDING=0.
//  2) Coalescing: REQ[1]=12'h111, then REQ[1]=12'h222 while channel 1's transfer is in flight.
//     -> second transfer carries LSB nibbles 22_20; exactly two DONE pulses.
//  3) Round-robin: REQ on all 4 channels on the same edge.
//     -> service order 0,1,2,3; then REQ[3],REQ[0] together with pointer=0 -> 0 then 3.
//  4) NACK: model returns ACK=1 on every attempt for channel 2.
//     -> 3 transfers, each separated by >=4 GO-low cycles; ERR_STICKY=1, ERR_CH=2, PENDING[2]=0, no DONE.
//  5) Timeout: END is held low.
//     -> GO drops after 63 XFER cycles and the transfer retries; a later success gives DONE.
//  6) Reset mid-transfer: RESET at XFER cycle 10.
//     -> GO=0, PENDING=0, BUSY=0 after that edge; no DONE and no ERR.

Source files
------------

// File: rtl/dac_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dac_update_scheduler
//  Purpose  : Shares one I2C DAC write controller between NUM_CH voice
//             channels with request coalescing, round-robin arbitration,
//             GO/END handshake, retry and error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module dac_update_scheduler #(
    parameter int          NUM_CH         = 4,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h0C,
    parameter logic [3:0]  CMD_NIB        = 4'h3,
    parameter int          MAX_RETRY      = 2,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 63
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [NUM_CH-1:0]      REQ,
    input  logic [12*NUM_CH-1:0]   REQ_DATA,
    input  logic                   ERR_CLR,
    output logic [31:0]            I2C_DATA,
    output logic                   GO,
    input  logic                   END,
    input  logic                   ACK,
    output logic [NUM_CH-1:0]      PENDING,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             DONE_CH,
    output logic                   ERR_STICKY,
    output logic [1:0]             ERR_CH
);

    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
    localparam int c_rty_w = $clog2(MAX_RETRY + 2);

    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(MAX_RETRY);
    localparam logic [1:0]         c_last_ch  = 2'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_XFER  = 3'd2,
        S_CHECK = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [11:0]          r_shadow [NUM_CH];
    logic [NUM_CH-1:0]    r_pending;
    logic [1:0]           r_ptr;
    logic [1:0]           r_ch;
    logic [31:0]          r_frame;
    logic                 r_go;
    logic [c_rty_w-1:0]   r_retry;
    logic                 r_retry_pend;
    logic [c_tmo_w-1:0]   r_tmo;
    logic                 r_tmo_flag;
    logic [c_gap_w-1:0]   r_gap;
    logic                 r_fresh;
    logic                 r_done;
    logic [1:0]           r_done_ch;
    logic                 r_err;
    logic [1:0]           r_err_ch;

    logic                 w_found;
    logic [1:0]           w_sel;
    logic [1:0]           w_idx;
    logic [3:0]           w_onehot;
    logic                 w_fail;
    logic                 w_exhausted;
    logic                 w_release;
    logic                 w_keep;
    logic [1:0]           w_next_ptr;
    logic [NUM_CH-1:0]    w_clr;

    // Round-robin: first pending channel at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = 2'((int'(r_ptr) + i) % NUM_CH);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_onehot    = 4'b0001 << w_sel;
    assign w_fail      = ACK || r_tmo_flag;
    assign w_exhausted = w_fail && (r_retry == c_rty_max);
    assign w_release   = (r_state == S_CHECK) && (!w_fail || w_exhausted);
    // A request that arrived after the frame was latched keeps the channel pending.
    assign w_keep      = REQ[r_ch] || r_fresh;
    assign w_next_ptr  = (r_ch == c_last_ch) ? 2'd0 : r_ch + 2'd1;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clr[i] = w_release && !w_keep && (2'(i) == r_ch);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= 12'h000;
            end
            r_pending    <= '0;
            r_ptr        <= 2'd0;
            r_ch         <= 2'd0;
            r_frame      <= 32'h0;
            r_go         <= 1'b0;
            r_retry      <= '0;
            r_retry_pend <= 1'b0;
            r_tmo        <= '0;
            r_tmo_flag   <= 1'b0;
            r_gap        <= '0;
            r_fresh      <= 1'b0;
            r_done       <= 1'b0;
            r_done_ch    <= 2'd0;
            r_err        <= 1'b0;
            r_err_ch     <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (REQ[i]) begin
                    r_shadow[i] <= REQ_DATA[12*i +: 12];
                end
            end
            r_pending <= (r_pending & ~w_clr) | REQ;
            r_done    <= 1'b0;
            if (ERR_CLR) begin
                r_err <= 1'b0;
            end
            if (r_state != S_IDLE && REQ[r_ch]) begin
                r_fresh <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ch    <= w_sel;
                        r_frame <= {SLAVE_ADDR, 1'b0, CMD_NIB, w_onehot,
                                    r_shadow[w_sel], 4'h0};
                        r_retry <= '0;
                        r_fresh <= REQ[w_sel];
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!END) begin
                        r_go       <= 1'b1;
                        r_tmo      <= '0;
                        r_tmo_flag <= 1'b0;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (END) begin
                        r_go    <= 1'b0;
                        r_state <= S_CHECK;
                    end else if (r_tmo == c_tmo_last) begin
                        r_go       <= 1'b0;
                        r_tmo_flag <= 1'b1;
                        r_state    <= S_CHECK;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_gap   <= '0;
                    r_state <= S_GAP;
                    if (!w_fail) begin
                        r_done       <= 1'b1;
                        r_done_ch    <= r_ch;
                        r_retry_pend <= 1'b0;
                        r_ptr        <= w_next_ptr;
                    end else if (!w_exhausted) begin
                        r_retry      <= r_retry + 1'b1;
                        r_retry_pend <= 1'b1;
                    end else begin
                        r_err        <= 1'b1;
                        r_err_ch     <= r_ch;
                        r_retry_pend <= 1'b0;
                        r_ptr        <= w_next_ptr;
                    end
                end
                S_GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_state <= r_retry_pend ? S_ARM : S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign I2C_DATA   = r_frame;
    assign GO         = r_go;
    assign PENDING    = r_pending;
    assign BUSY       = (r_state != S_IDLE);
    assign DONE       = r_done;
    assign DONE_CH    = r_done_ch;
    assign ERR_STICKY = r_err;
    assign ERR_CH     = r_err_ch;

endmodule
`default_nettype wire

// File: tb/tb_dac_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_update_scheduler
//  Purpose  : Scoreboard bench with an I2C controller model for the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_update_scheduler;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [47:0] REQ_DATA;
    logic        ERR_CLR;
    logic [31:0] I2C_DATA;
    logic        GO;
    logic        END;
    logic        ACK;
    logic [3:0]  PENDING;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  DONE_CH;
    logic        ERR_STICKY;
    logic [1:0]  ERR_CH;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_frame [$];
    logic [1:0]  exp_done  [$];

    logic [3:0] nack_mask = 4'b0000;
    logic       hang      = 1'b0;
    int         m_cnt;

    int done_cnt  = 0;
    int fall_cnt  = 0;
    int hi_cnt    = 0;
    int low_cnt   = 0;
    int last_hi   = 0;
    bit seen_fall = 1'b0;
    bit go_q      = 1'b0;

    always #5 CLOCK = ~CLOCK;

    dac_update_scheduler dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .REQ        (REQ),
        .REQ_DATA   (REQ_DATA),
        .ERR_CLR    (ERR_CLR),
        .I2C_DATA   (I2C_DATA),
        .GO         (GO),
        .END        (END),
        .ACK        (ACK),
        .PENDING    (PENDING),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .DONE_CH    (DONE_CH),
        .ERR_STICKY (ERR_STICKY),
        .ERR_CH     (ERR_CH)
    );

    // Controller model: counter runs while GO, END rises ~41 cycles in.
    always @(posedge CLOCK) begin
        if (RESET || !GO) begin
            m_cnt <= 0;
            END   <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (!hang && m_cnt == 40) END <= 1'b1;
        end
    end
    assign ACK = |(nack_mask & I2C_DATA[19:16]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame(input int ch, input logic [11:0] v);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        return {7'h0C, 1'b0, 4'h3, oh, v, 4'h0};
    endfunction

    // Monitor: frames at GO rise, DONE channel, GO high/low run lengths.
    always @(negedge CLOCK) begin
        if (GO && !go_q) begin
            if (exp_frame.size() == 0) check("unexpected_xfer", 32'd1, 32'd0);
            else check("frame", I2C_DATA, exp_frame.pop_front());
            if (seen_fall) check("go_low_gap_ge4", 32'(low_cnt >= 4), 32'd1);
            hi_cnt = 1;
        end else if (GO) begin
            hi_cnt++;
        end
        if (!GO && go_q) begin
            last_hi   = hi_cnt;
            seen_fall = 1'b1;
            low_cnt   = 1;
            fall_cnt++;
        end else if (!GO) begin
            low_cnt++;
        end
        if (DONE) begin
            done_cnt++;
            if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("done_ch", 32'(DONE_CH), 32'(exp_done.pop_front()));
        end
        if (RESET) seen_fall = 1'b0;
        go_q = GO;
    end

    task automatic step();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic pulse_req(input logic [3:0] mask, input logic [47:0] data);
        REQ      = mask;
        REQ_DATA = data;
        step();
        REQ      = 4'h0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(!BUSY && PENDING == 4'h0) && n < budget);
        if (n >= budget) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_go_high(input int budget);
        int n = 0;
        while (!GO && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("go_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int d0;
        int f0;
        int n;
        RESET    = 1'b1;
        REQ      = 4'h0;
        REQ_DATA = 48'h0;
        ERR_CLR  = 1'b0;
        step();
        do_reset();

        check("rst_go", 32'(GO), 32'd0);
        check("rst_pending", 32'(PENDING), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR_STICKY), 32'd0);
        check("rst_data", I2C_DATA, 32'h0);

        // Single update with latency checks
        exp_frame.push_back(32'h1831ABC0);
        exp_done.push_back(2'd0);
        d0 = done_cnt;
        pulse_req(4'b0001, 48'hABC);
        check("t_pending", 32'(PENDING), 32'h1);
        check("t_go", 32'(GO), 32'd0);
        step();
        check("t1_busy", 32'(BUSY), 32'd1);
        check("t1_go", 32'(GO), 32'd0);
        check("t1_data", I2C_DATA, 32'h1831ABC0);
        step();
        check("t2_go", 32'(GO), 32'd1);
        wait_idle(2000);
        check("single_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("single_pending", 32'(PENDING), 32'h0);

        // Coalescing: new value arrives while channel 1 is in flight
        exp_frame.push_back(frame(1, 12'h111));
        exp_frame.push_back(frame(1, 12'h222));
        exp_done.push_back(2'd1);
        exp_done.push_back(2'd1);
        d0 = done_cnt;
        pulse_req(4'b0010, 48'h111 << 12);
        wait_go_high(50);
        pulse_req(4'b0010, 48'h222 << 12);
        wait_idle(3000);
        check("coalesce_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Round-robin from pointer 0
        do_reset();
        for (int c = 0; c < 4; c++) begin
            exp_frame.push_back(frame(c, 12'(12'h100 + c)));
            exp_done.push_back(2'(c));
        end
        pulse_req(4'b1111, {12'h103, 12'h102, 12'h101, 12'h100});
        wait_idle(5000);
        exp_frame.push_back(frame(0, 12'h200));
        exp_frame.push_back(frame(3, 12'h203));
        exp_done.push_back(2'd0);
        exp_done.push_back(2'd3);
        pulse_req(4'b1001, {12'h203, 12'h000, 12'h000, 12'h200});
        wait_idle(3000);
        check("rr_queue_empty", 32'(exp_done.size()), 32'd0);

        // NACK on every attempt for channel 2
        nack_mask = 4'b0100;
        d0 = done_cnt;
        f0 = fall_cnt;
        for (int k = 0; k < 3; k++) exp_frame.push_back(frame(2, 12'h5A5));
        pulse_req(4'b0100, 48'h5A5 << 24);
        wait_idle(3000);
        check("nack_xfers", 32'(fall_cnt - f0), 32'd3);
        check("nack_err", 32'(ERR_STICKY), 32'd1);
        check("nack_err_ch", 32'(ERR_CH), 32'd2);
        check("nack_pending2", 32'(PENDING[2]), 32'd0);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        nack_mask = 4'b0000;
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        check("err_clr", 32'(ERR_STICKY), 32'd0);

        // Timeout: END held low on the first attempt
        hang = 1'b1;
        f0 = fall_cnt;
        exp_frame.push_back(frame(3, 12'h777));
        exp_frame.push_back(frame(3, 12'h777));
        exp_done.push_back(2'd3);
        d0 = done_cnt;
        pulse_req(4'b1000, 48'h777 << 36);
        n = 0;
        while (fall_cnt == f0 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("tmo_wait", 32'd1, 32'd0);
        check("tmo_go_high", 32'(last_hi), 32'd63);
        hang = 1'b0;
        wait_idle(2000);
        check("tmo_done", 32'(done_cnt - d0), 32'd1);
        check("tmo_no_err", 32'(ERR_STICKY), 32'd0);

        // Reset mid-transfer
        exp_frame.push_back(frame(0, 12'h321));
        d0 = done_cnt;
        pulse_req(4'b0001, 48'h321);
        wait_go_high(50);
        repeat (10) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_go", 32'(GO), 32'd0);
        check("mid_rst_pending", 32'(PENDING), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        repeat (100) step();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_no_err", 32'(ERR_STICKY), 32'd0);
        check("frame_queue_empty", 32'(exp_frame.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
